pwm_sample_scheduler: RTL and testbench

- Paces the 8-bit audio samples that feed the PWM DAC accumulator at a fixed sample rate.
- Sits between the UART byte receiver (valid/data strobe, no backpressure) and the PWM DAC sample register.
- Buffers bursty incoming bytes in a small FIFO, primes before playback, and releases one sample per sample tick.
- Holds a defined level on underflow, returns to midscale after a prolonged starve, and flags overflow/underflow.

---
 rtl/pwm_sample_scheduler.sv | 178 +++++++++++++++++
 tb/tb_pwm_sample_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sample_scheduler.sv
// pwm_sample_scheduler: paces UART-fed 8-bit samples into the PWM DAC at a
// fixed rate. Bursty bytes land in a small FIFO; playback starts once the
// FIFO is primed, releases one sample per tick, holds on underflow and falls
// back to midscale after a prolonged starve.
// Optional build macro PWM_SCHED_STATS_EN adds saturating underflow/overflow
// event counters.
module pwm_sample_scheduler #(
  parameter int         CLK_DIV     = 3125,
  parameter int         FIFO_AW     = 4,
  parameter int         PRIME_LEVEL = 8,
  parameter logic [7:0] IDLE_LEVEL  = 8'h80,
  parameter int         IDLE_TICKS  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic [7:0]         sample_out,
  output logic               sample_strobe,
  output logic               playing,
  output logic               underflow,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_level
`ifdef PWM_SCHED_STATS_EN
  ,
  output logic [15:0]        underflow_count,
  output logic [15:0]        overflow_count
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW    = $clog2(IDLE_TICKS + 1);

  localparam logic [CW-1:0]    TICK_LAST  = CW'(CLK_DIV - 1);
  localparam logic [SW-1:0]    STARVE_MAX = SW'(IDLE_TICKS);
  localparam logic [FIFO_AW:0] PRIME_W    = (FIFO_AW + 1)'(PRIME_LEVEL);
  localparam logic [FIFO_AW:0] FULL_W     = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_STARVED} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      tick_cnt;
  logic               tick;
  logic [SW-1:0]      starve_cnt, starve_nxt, starve_inc;
  logic [7:0]         out_nxt;
  logic               strobe_nxt, unf_nxt;
  logic               pop, push, drop;
  logic               full, empty, primed;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]         rd_data;

  assign tick       = (tick_cnt == TICK_LAST);
  assign full       = (fifo_level == FULL_W);
  assign empty      = (fifo_level == '0);
  assign primed     = (fifo_level >= PRIME_W);
  assign rd_data    = mem[rd_ptr];
  assign starve_inc = starve_cnt + SW'(1);
  assign playing    = (state == S_PLAY);

  // A push may take the slot freed by a same-cycle pop; disabled input is discarded silently.
  assign push = enable & in_valid & (~full | pop);
  assign drop = enable & in_valid & full & ~pop;

  // Free-running sample-rate divider, independent of enable.
  always_ff @(posedge clk) begin
    if (!rst_n || tick) tick_cnt <= '0;
    else                tick_cnt <= tick_cnt + CW'(1);
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy; disabling playback flushes everything.
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // State, starve counter and registered DAC-side outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      starve_cnt    <= '0;
      sample_out    <= IDLE_LEVEL;
      sample_strobe <= 1'b0;
      underflow     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state         <= state_nxt;
      starve_cnt    <= starve_nxt;
      sample_out    <= out_nxt;
      sample_strobe <= strobe_nxt;
      underflow     <= unf_nxt;
      overflow      <= drop;
    end
  end

  // Next-state and output decode; the pop decision is made only in the tick cycle.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    out_nxt    = sample_out;
    strobe_nxt = 1'b0;
    unf_nxt    = 1'b0;
    pop        = 1'b0;
    if (!enable) begin
      state_nxt  = S_IDLE;
      starve_nxt = '0;
      out_nxt    = IDLE_LEVEL;
      strobe_nxt = (sample_out != IDLE_LEVEL);
    end else begin
      case (state)
        S_IDLE: begin
          if (primed) state_nxt = S_PLAY;
        end
        S_PLAY: begin
          if (tick) begin
            if (!empty) begin
              pop        = 1'b1;
              out_nxt    = rd_data;
              strobe_nxt = 1'b1;
            end else begin
              unf_nxt    = 1'b1;
              starve_nxt = SW'(1);
              state_nxt  = S_STARVED;
            end
          end
        end
        S_STARVED: begin
          // Refill wins over the idle fallback; popping restarts on the next tick.
          if (primed) begin
            state_nxt  = S_PLAY;
            starve_nxt = '0;
          end else if (tick) begin
            starve_nxt = starve_inc;
            if (starve_inc >= STARVE_MAX) begin
              state_nxt  = S_IDLE;
              starve_nxt = '0;
              out_nxt    = IDLE_LEVEL;
              strobe_nxt = 1'b1;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef PWM_SCHED_STATS_EN
  // Saturating event counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underflow_count <= '0;
      overflow_count  <= '0;
    end else begin
      if (underflow && underflow_count != 16'hFFFF) underflow_count <= underflow_count + 16'd1;
      if (overflow  && overflow_count  != 16'hFFFF) overflow_count  <= overflow_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// tb_pwm_sample_scheduler: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based model.
module tb_pwm_sample_scheduler;
  localparam int         CLK_DIV     = 4;
  localparam int         FIFO_AW     = 2;
  localparam int         PRIME_LEVEL = 2;
  localparam int         IDLE_TICKS  = 3;
  localparam int         DEPTH       = 4;
  localparam logic [7:0] IDLE_LEVEL  = 8'h80;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0, enable = 1'b0, in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic [7:0]        sample_out;
  logic              sample_strobe, playing, underflow, overflow;
  logic [FIFO_AW:0]  fifo_level;
`ifdef PWM_SCHED_STATS_EN
  logic [15:0]       underflow_count, overflow_count;
`endif

  pwm_sample_scheduler #(
    .CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW), .PRIME_LEVEL(PRIME_LEVEL),
    .IDLE_LEVEL(IDLE_LEVEL), .IDLE_TICKS(IDLE_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .sample_out(sample_out), .sample_strobe(sample_strobe), .playing(playing),
    .underflow(underflow), .overflow(overflow), .fifo_level(fifo_level)
`ifdef PWM_SCHED_STATS_EN
    , .underflow_count(underflow_count), .overflow_count(overflow_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  // Reference model: FIFO as a queue, sample clock as a cycle count modulo CLK_DIV.
  int         m_cnt = 0;
  logic [7:0] m_q[$];
  logic [7:0] m_out = IDLE_LEVEL;
  bit         m_strobe, m_unf, m_ovf, m_play, m_starved;
  int         m_starve = 0;
  int         m_ucnt = 0, m_ocnt = 0;

  task automatic model_step(input bit r, input bit e, input bit v, input logic [7:0] d);
    bit tick, popped;
    int lvl;
    if (!r) begin
      m_cnt = 0; m_q.delete(); m_out = IDLE_LEVEL;
      m_strobe = 0; m_unf = 0; m_ovf = 0; m_play = 0; m_starved = 0;
      m_starve = 0; m_ucnt = 0; m_ocnt = 0;
      return;
    end
    if (m_unf && m_ucnt < 65535) m_ucnt++;
    if (m_ovf && m_ocnt < 65535) m_ocnt++;
    tick = (m_cnt == CLK_DIV - 1);
    m_cnt = (m_cnt + 1) % CLK_DIV;
    lvl = m_q.size();
    popped = 0; m_strobe = 0; m_unf = 0; m_ovf = 0;
    if (!e) begin
      m_strobe = (m_out != IDLE_LEVEL);
      m_out = IDLE_LEVEL; m_q.delete();
      m_play = 0; m_starved = 0; m_starve = 0;
      return;
    end
    if (m_play) begin
      if (tick) begin
        if (lvl > 0) begin
          m_out = m_q.pop_front(); popped = 1; m_strobe = 1;
        end else begin
          m_unf = 1; m_play = 0; m_starved = 1; m_starve = 1;
        end
      end
    end else if (m_starved) begin
      if (lvl >= PRIME_LEVEL) begin
        m_starved = 0; m_play = 1; m_starve = 0;
      end else if (tick) begin
        m_starve++;
        if (m_starve >= IDLE_TICKS) begin
          m_starved = 0; m_starve = 0; m_out = IDLE_LEVEL; m_strobe = 1;
        end
      end
    end else if (lvl >= PRIME_LEVEL) begin
      m_play = 1;
    end
    if (v) begin
      if (lvl < DEPTH || popped) m_q.push_back(d);
      else m_ovf = 1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc_no, act, exp);
    end
  endtask

  // One clock: drive at negedge, step model at posedge, compare at next negedge.
  task automatic cyc(input bit r, input bit e, input bit v, input logic [7:0] d);
    rst_n = r; enable = e; in_valid = v; in_data = d;
    @(posedge clk);
    model_step(r, e, v, d);
    cyc_no++;
    @(negedge clk);
    chk("outputs{out,stb,play,unf,ovf,lvl}",
        {17'd0, sample_out, sample_strobe, playing, underflow, overflow, fifo_level},
        {17'd0, m_out, m_strobe, m_play, m_unf, m_ovf, 3'(m_q.size())});
`ifdef PWM_SCHED_STATS_EN
    chk("stats{unf_cnt,ovf_cnt}", {underflow_count, overflow_count}, {16'(m_ucnt), 16'(m_ocnt)});
`endif
  endtask

  typedef struct {
    bit r, e, v;
    logic [7:0] d;
    logic [7:0] eo;
    bit es, ep, eu, eov;
    int el;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit r, input bit e, input bit v, input logic [7:0] d,
                              input logic [7:0] eo, input bit es, input bit ep, input bit eu,
                              input bit eov, input int el, input int n = 1);
    vec_t t;
    t.r = r; t.e = e; t.v = v; t.d = d;
    t.eo = eo; t.es = es; t.ep = ep; t.eu = eu; t.eov = eov; t.el = el;
    for (int i = 0; i < n; i++) tbl.push_back(t);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got[$];
    logic [7:0] exp_drain[4];
    logic [7:0] act;
    int nstb, nunf, dens;
    bit ready;

    // Reset 3 cycles, 20 idle cycles, then prime/play/underflow/starve-to-idle.
    // Ticks land on every 4th edge after reset release (edges 4, 8, ... 24, 28, ...).
    add(0,0,0,8'h00, 8'h80,0,0,0,0,0, 3);
    add(1,0,0,8'h00, 8'h80,0,0,0,0,0, 20);
    add(1,1,1,8'h10, 8'h80,0,0,0,0,1);
    add(1,1,1,8'h20, 8'h80,0,0,0,0,2);
    add(1,1,1,8'h30, 8'h80,0,1,0,0,3);
    add(1,1,0,8'h00, 8'h10,1,1,0,0,2);
    add(1,1,0,8'h00, 8'h10,0,1,0,0,2, 3);
    add(1,1,0,8'h00, 8'h20,1,1,0,0,1);
    add(1,1,0,8'h00, 8'h20,0,1,0,0,1, 3);
    add(1,1,0,8'h00, 8'h30,1,1,0,0,0);
    add(1,1,0,8'h00, 8'h30,0,1,0,0,0, 3);
    add(1,1,0,8'h00, 8'h30,0,0,1,0,0);
    add(1,1,0,8'h00, 8'h30,0,0,0,0,0, 7);
    add(1,1,0,8'h00, 8'h80,1,0,0,0,0);
    add(1,1,0,8'h00, 8'h80,0,0,0,0,0, 2);

    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl[%0d]", i),
          {17'd0, sample_out, sample_strobe, playing, underflow, overflow, fifo_level},
          {17'd0, tbl[i].eo, tbl[i].es, tbl[i].ep, tbl[i].eu, tbl[i].eov, 3'(tbl[i].el)});
    end

    // Overflow: five pushes with no pop in between (tick falls while still IDLE).
    for (int k = 0; k < 8 && m_cnt != 2; k++) cyc(1,1,0,8'h00);
    cyc(1,1,1,8'h41);
    cyc(1,1,1,8'h42);
    cyc(1,1,1,8'h43);
    cyc(1,1,1,8'h44);
    chk("ovf_before_full", {31'd0, overflow}, 32'd0);
    chk("lvl_full", {29'd0, fifo_level}, 32'd4);
    cyc(1,1,1,8'h45);
    chk("ovf_pulse", {31'd0, overflow}, 32'd1);
    chk("lvl_after_drop", {29'd0, fifo_level}, 32'd4);

    // Push in the tick cycle while full: accepted because of the same-cycle pop.
    cyc(1,1,1,8'h5A);
    chk("ovf_push_pop", {31'd0, overflow}, 32'd0);
    chk("lvl_push_pop", {29'd0, fifo_level}, 32'd4);
    chk("first_pop", {23'd0, sample_strobe, sample_out}, {23'd0, 1'b1, 8'h41});

    exp_drain[0] = 8'h42; exp_drain[1] = 8'h43; exp_drain[2] = 8'h44; exp_drain[3] = 8'h5A;
    for (int k = 0; k < 16; k++) begin
      cyc(1,1,0,8'h00);
      if (sample_strobe) got.push_back(sample_out);
    end
    chk("drain_count", got.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      act = (i < got.size()) ? got[i] : 8'hxx;
      chk($sformatf("drain[%0d]", i), {24'd0, act}, {24'd0, exp_drain[i]});
    end
    nstb = 0; nunf = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1,1,0,8'h00);
      nstb += int'(sample_strobe);
      nunf += int'(underflow);
    end
    chk("no_fifth_byte", nstb, 32'd0);
    chk("unf_after_drain", nunf, 32'd1);

    // Refill from STARVED to PLAY with level 3, then disable.
    ready = 0;
    for (int k = 0; k < 40; k++) begin
      if (m_play && m_q.size() == 3 && m_out != IDLE_LEVEL) begin
        ready = 1;
        break;
      end
      cyc(1,1, m_q.size() < 3, 8'h60 + 8'(k));
    end
    chk("prep_play_lvl3", {31'd0, ready}, 32'd1);
    cyc(1,0,1,8'hC3);
    chk("dis_lvl", {29'd0, fifo_level}, 32'd0);
    chk("dis_out_stb", {23'd0, sample_strobe, sample_out}, {23'd0, 1'b1, IDLE_LEVEL});
    chk("dis_ovf_play", {30'd0, overflow, playing}, 32'd0);
    cyc(1,0,0,8'h00);
    chk("dis_after", {26'd0, overflow, sample_strobe, fifo_level}, 32'd0);

    // Randomized traffic with varying input density, rare resets and disables.
    dens = 50;
    for (int k = 0; k < 3000; k++) begin
      if (k % 250 == 0) dens = int'($urandom_range(0, 100));
      cyc($urandom_range(0, 199) != 0,
          $urandom_range(0, 49) != 0,
          int'($urandom_range(0, 99)) < dens,
          8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
